// File: rtl/ftdi_245fifo_bus_arbiter.sv
// Direction scheduler for the shared FT60x 245-synchronous FIFO bus: grants the
// data/BE bus to RX or TX, inserts turnaround cycles, bounds bursts, alternates on ties.
module ftdi_245fifo_bus_arbiter #(
   parameter int MAX_BURST = 256,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 usb_clk,
   input  logic                 usb_rstn,
   input  logic                 usb_txe_n,
   input  logic                 usb_rxf_n,
   input  logic                 tx_req,
   input  logic                 tx_last,
   input  logic                 rx_afull,
   output logic                 usb_oe_n,
   output logic                 usb_rd_n,
   output logic                 usb_wr_n,
   output logic                 bus_t,
   output logic                 rx_push,
   output logic                 tx_pop,
   output logic                 rx_grant,
   output logic                 tx_grant,
   output logic [CNT_WIDTH-1:0] burst_cnt
);

   typedef enum logic [6:0] {
      IDLE    = 7'b0000001,
      RX_OE   = 7'b0000010,
      RX_RD   = 7'b0000100,
      RX_END  = 7'b0001000,
      TX_TURN = 7'b0010000,
      TX_WR   = 7'b0100000,
      TX_END  = 7'b1000000
   } state_t;

   localparam logic [CNT_WIDTH-1:0] BURST_LAST = CNT_WIDTH'(MAX_BURST - 1);

   state_t state;
   logic   last_dir_rx;
   logic   rx_pend;
   logic   tx_pend;

   assign rx_pend = ~usb_rxf_n & ~rx_afull;
   assign tx_pend = ~usb_txe_n & tx_req;

   // Strobes decode straight from the state register so reset releases the bus at once.
   assign usb_oe_n = ~((state == RX_OE) | (state == RX_RD));
   assign usb_rd_n = ~(state == RX_RD);
   assign bus_t    = ~((state == TX_TURN) | (state == TX_WR));
   assign usb_wr_n = ~((state == TX_WR) & tx_req);
   assign rx_push  = (state == RX_RD) & ~usb_rxf_n;
   assign tx_pop   = (state == TX_WR) & tx_req & ~usb_txe_n;
   assign rx_grant = (state == RX_OE) | (state == RX_RD) | (state == RX_END);
   assign tx_grant = (state == TX_TURN) | (state == TX_WR) | (state == TX_END);

   always_ff @(posedge usb_clk or negedge usb_rstn) begin
      if (!usb_rstn) begin
         state       <= IDLE;
         burst_cnt   <= '0;
         last_dir_rx <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // On a tie the direction that did not own the bus last goes first.
               if (rx_pend && (!tx_pend || !last_dir_rx)) begin
                  state     <= RX_OE;
                  burst_cnt <= '0;
               end else if (tx_pend) begin
                  state     <= TX_TURN;
                  burst_cnt <= '0;
               end
            end
            RX_OE:   state <= RX_RD;
            RX_RD: begin
               if (rx_push)
                  burst_cnt <= burst_cnt + CNT_WIDTH'(1);
               if (usb_rxf_n || rx_afull || (rx_push && (burst_cnt == BURST_LAST)))
                  state <= RX_END;
            end
            RX_END: begin
               state       <= IDLE;
               last_dir_rx <= 1'b1;
            end
            TX_TURN: state <= TX_WR;
            TX_WR: begin
               if (tx_pop)
                  burst_cnt <= burst_cnt + CNT_WIDTH'(1);
               if (usb_txe_n || !tx_req || (tx_pop && tx_last) ||
                   (tx_pop && (burst_cnt == BURST_LAST)))
                  state <= TX_END;
            end
            TX_END: begin
               state       <= IDLE;
               last_dir_rx <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The chip and the FPGA must never drive the bus at the same time.
   assert property (@(posedge usb_clk) disable iff (!usb_rstn) !(!bus_t && !usb_oe_n));

endmodule

// File: tb/tb_ftdi_245fifo_bus_arbiter.sv
// Scoreboard bench for ftdi_245fifo_bus_arbiter with a behavioural FT60x / buffer model.
module tb_ftdi_245fifo_bus_arbiter;
   localparam int MB = 16;
   localparam int CW = 16;

   logic          usb_clk = 1'b0;
   logic          usb_rstn = 1'b0;
   logic          usb_txe_n, usb_rxf_n, tx_req, tx_last, rx_afull;
   logic          usb_oe_n, usb_rd_n, usb_wr_n, bus_t, rx_push, tx_pop, rx_grant, tx_grant;
   logic [CW-1:0] burst_cnt;

   int   rx_total = 0, rx_taken = 0, tx_total = 0, tx_popped = 0;
   int   tx_last_at = 0, afull_thr = 1 << 30;
   logic txe_n_drv = 1'b1;
   int   n_cmp = 0, n_bad = 0;

   typedef struct { bit is_tx; int words; } burst_t;
   burst_t exp_burst_q[$];
   int     exp_rx_q[$];
   int     exp_tx_q[$];

   ftdi_245fifo_bus_arbiter #(.MAX_BURST(MB), .CNT_WIDTH(CW)) dut (
      .usb_clk(usb_clk), .usb_rstn(usb_rstn), .usb_txe_n(usb_txe_n), .usb_rxf_n(usb_rxf_n),
      .tx_req(tx_req), .tx_last(tx_last), .rx_afull(rx_afull), .usb_oe_n(usb_oe_n),
      .usb_rd_n(usb_rd_n), .usb_wr_n(usb_wr_n), .bus_t(bus_t), .rx_push(rx_push),
      .tx_pop(tx_pop), .rx_grant(rx_grant), .tx_grant(tx_grant), .burst_cnt(burst_cnt)
   );

   always #5 usb_clk = ~usb_clk;

   // Chip RX FIFO and FPGA TX buffer model: word k carries value k.
   assign usb_rxf_n = (rx_total <= rx_taken);
   assign rx_afull  = (rx_taken >= afull_thr);
   assign tx_req    = (tx_total > tx_popped);
   assign tx_last   = tx_req && (tx_popped + 1 == tx_last_at);
   assign usb_txe_n = txe_n_drv;

   always @(posedge usb_clk) begin
      if (rx_push) rx_taken  <= rx_taken + 1;
      if (tx_pop)  tx_popped <= tx_popped + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input int act);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got %0d, expected nothing", name, act);
   endtask

   // Monitor: pops expectations whenever the DUT moves a word or closes a burst.
   initial begin
      logic   p_bus_t, p_wr_n, p_oe_n, p_rd_n, p_grant, p_end;
      logic   is_end;
      burst_t b;
      p_bus_t = 1'b1; p_wr_n = 1'b1; p_oe_n = 1'b1; p_rd_n = 1'b1; p_grant = 1'b0; p_end = 1'b0;
      forever begin
         @(negedge usb_clk);
         is_end = 1'b0;
         if (usb_rstn) begin
            if (rx_push) begin
               if (exp_rx_q.size() == 0) unexpected("rx word", rx_taken + 1);
               else check("rx word", rx_taken + 1, exp_rx_q.pop_front());
            end
            if (tx_pop) begin
               if (exp_tx_q.size() == 0) unexpected("tx word", tx_popped + 1);
               else check("tx word", tx_popped + 1, exp_tx_q.pop_front());
            end
            if (!usb_wr_n && p_wr_n) check("bus_t low cycle before first wr_n", int'(p_bus_t), 0);
            if (!usb_rd_n && p_rd_n) check("oe_n low cycle before first rd_n", int'(p_oe_n), 0);
            if (p_end) check("idle cycle after burst end", int'({rx_grant, tx_grant}), 0);
            if (rx_grant && !p_grant) check("rx grant opens in RX_OE", int'({usb_oe_n, usb_rd_n}), 1);
            if (tx_grant && !p_grant) check("tx grant opens in TX_TURN", int'({bus_t, usb_wr_n}), 1);
            is_end = (rx_grant && usb_oe_n) || (tx_grant && bus_t);
            if (is_end) begin
               if (exp_burst_q.size() == 0) unexpected("burst end", int'(burst_cnt));
               else begin
                  b = exp_burst_q.pop_front();
                  check("burst direction is_tx", int'(tx_grant), int'(b.is_tx));
                  check("burst word count", int'(burst_cnt), b.words);
               end
            end
         end
         p_bus_t = bus_t; p_wr_n = usb_wr_n; p_oe_n = usb_oe_n; p_rd_n = usb_rd_n;
         p_grant = rx_grant | tx_grant; p_end = is_end;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge usb_clk);
      #1;
   endtask

   task automatic add_rx(input int n);
      for (int i = 1; i <= n; i++) exp_rx_q.push_back(rx_total + i);
      rx_total += n;
   endtask

   task automatic add_tx(input int n, input int last_pos);
      for (int i = 1; i <= n; i++) exp_tx_q.push_back(tx_total + i);
      tx_last_at = (last_pos > 0) ? tx_total + last_pos : 0;
      tx_total  += n;
   endtask

   task automatic exp_burst(input bit is_tx, input int words);
      burst_t b;
      b.is_tx = is_tx;
      b.words = words;
      exp_burst_q.push_back(b);
   endtask

   task automatic drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_burst_q.size() + exp_rx_q.size() + exp_tx_q.size()) != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      cyc(4);
      check({name, " outstanding expectations"},
            exp_burst_q.size() + exp_rx_q.size() + exp_tx_q.size(), 0);
      check({name, " bus released"}, int'({rx_grant, tx_grant}), 0);
   endtask

   initial begin
      int k;
      int base;
      cyc(3);
      check("reset oe_n", int'(usb_oe_n), 1);
      check("reset rd_n", int'(usb_rd_n), 1);
      check("reset wr_n", int'(usb_wr_n), 1);
      check("reset bus_t", int'(bus_t), 1);
      check("reset push/pop", int'({rx_push, tx_pop}), 0);
      check("reset grants", int'({rx_grant, tx_grant}), 0);
      check("reset burst_cnt", int'(burst_cnt), 0);
      usb_rstn = 1'b1;
      cyc(2);

      // RX only, 12 words
      exp_burst(1'b0, 12);
      add_rx(12);
      drain("rx only", 200);
      check("burst_cnt held in idle after rx", int'(burst_cnt), 12);

      // TX only, 14 words with tx_last on word 11
      txe_n_drv = 1'b0;
      exp_burst(1'b1, 11);
      exp_burst(1'b1, 3);
      add_tx(14, 11);
      drain("tx only", 200);
      check("burst_cnt held in idle after tx", int'(burst_cnt), 3);

      // Both pending continuously: alternate with MAX_BURST words each
      for (int i = 0; i < 4; i++) begin
         exp_burst(1'b0, MB);
         exp_burst(1'b1, MB);
      end
      add_rx(64);
      add_tx(64, 0);
      drain("alternation", 800);

      // RX only, 40 words split by the burst bound
      exp_burst(1'b0, 16);
      exp_burst(1'b0, 16);
      exp_burst(1'b0, 8);
      add_rx(40);
      drain("rx 40 words", 400);

      // rx_afull rises while word 5 is pushed; TX is served while RX is blocked
      afull_thr = rx_total + 4;
      exp_burst(1'b0, 5);
      add_rx(10);
      k = 0;
      while (!rx_grant && k < 20) begin cyc(1); k++; end
      check("rx granted before afull", int'(rx_grant), 1);
      exp_burst(1'b1, 3);
      add_tx(3, 0);
      cyc(30);
      check("no rx re-grant while afull", int'(rx_grant), 0);
      check("rx words left while afull", exp_rx_q.size(), 5);
      check("tx served while afull", exp_tx_q.size(), 0);
      afull_thr = 1 << 30;
      exp_burst(1'b0, 5);
      drain("afull", 200);

      // Reset mid TX_WR; pending RX wins the tie after release
      base = tx_total;
      add_tx(10, 0);
      k = 0;
      while (tx_popped < base + 3 && k < 50) begin cyc(1); k++; end
      check("tx pops before reset", tx_popped, base + 3);
      #2;
      usb_rstn = 1'b0;
      #1;
      check("async reset wr_n", int'(usb_wr_n), 1);
      check("async reset bus_t", int'(bus_t), 1);
      check("async reset tx_pop", int'(tx_pop), 0);
      check("async reset tx_grant", int'(tx_grant), 0);
      check("async reset burst_cnt", int'(burst_cnt), 0);
      add_rx(4);
      exp_burst(1'b0, 4);
      exp_burst(1'b1, 7);
      cyc(3);
      usb_rstn = 1'b1;
      drain("after reset", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ftdi_245fifo_bus_arbiter.md
Name: ftdi_245fifo_bus_arbiter

Overview:
Direction scheduler for the shared FT60x 245-synchronous FIFO bus. It grants the bidirectional data/BE bus to either the receive path (chip to FPGA) or the transmit path (FPGA to chip). It inserts bus-turnaround cycles, bounds each burst, and alternates fairly when both directions are pending. It drives the chip strobes and tristate control, and issues per-word push/pop strobes to the RX/TX buffers inside ftdi_245fifo_top.

Parameters:
MAX_BURST, 256, maximum words moved per grant before the bus is re-arbitrated (2-65535)
CNT_WIDTH, 16, width of the burst counter; must hold MAX_BURST

Ports:
usb_clk  in  1  FT60x bus clock; the only clock
usb_rstn  in  1  asynchronous active-low reset
usb_txe_n  in  1  chip TX FIFO has space when low
usb_rxf_n  in  1  chip RX FIFO has data when low
tx_req  in  1  TX buffer holds a word ready to send
tx_last  in  1  word presented with tx_req is the last of its packet
rx_afull  in  1  RX buffer prog_full; no further reads may start
usb_oe_n  out  1  chip data output enable
usb_rd_n  out  1  chip read strobe
usb_wr_n  out  1  chip write strobe
bus_t  out  1  tristate control for data and BE: 1 = input, 0 = output
rx_push  out  1  capture usb_data_i/usb_be_i into the RX buffer this cycle
tx_pop  out  1  current TX word is accepted by the chip this cycle
rx_grant  out  1  RX direction owns the bus (states RX_OE..RX_END)
tx_grant  out  1  TX direction owns the bus (states TX_TURN..TX_END)
burst_cnt  out  CNT_WIDTH  words moved in the current grant

Behaviour:
- Reset (usb_rstn=0, any time, asynchronous): state=IDLE; usb_oe_n=usb_rd_n=usb_wr_n=1; bus_t=1; rx_push=tx_pop=0; both grants=0; burst_cnt=0; last_dir=TX. Consequence: RX wins the first tie. An in-flight burst is abandoned with no further push/pop.
- States are one-hot: IDLE, RX_OE, RX_RD, RX_END, TX_TURN, TX_WR, TX_END.
- Signals are decoded from the state register:
  - usb_oe_n = 0 in RX_OE and RX_RD.
  - usb_rd_n = 0 in RX_RD.
  - bus_t = 0 in TX_TURN and TX_WR only.
  - usb_wr_n = ~(TX_WR & tx_req).
  - rx_push = RX_RD & ~usb_rxf_n.
  - tx_pop = TX_WR & tx_req & ~usb_txe_n.
- Pending conditions: rx_pend = ~usb_rxf_n & ~rx_afull; tx_pend = ~usb_txe_n & tx_req.
- IDLE:
  - Only rx_pend: go to RX_OE.
  - Only tx_pend: go to TX_TURN.
  - Both pending: go to the direction opposite last_dir.
  - Neither pending: stay in IDLE.
  - IDLE lasts at least 1 cycle between grants.
- RX_OE: 1 turnaround cycle, then RX_RD unconditionally. burst_cnt is cleared on entry.
- RX_RD:
  - burst_cnt increments on each rx_push.
  - Go to RX_END when usb_rxf_n=1, or rx_afull=1, or (rx_push and burst_cnt==MAX_BURST-1).
  - The word pushed on the exit cycle is counted.
  - RX_END lasts 1 cycle (oe_n/rd_n high, bus_t=1), then IDLE, and last_dir is set to RX.
- TX_TURN: 1 cycle with bus_t=0 before any strobe. burst_cnt is cleared on entry.
- TX_WR:
  - burst_cnt increments on each tx_pop.
  - Go to TX_END when usb_txe_n=1, or tx_req=0, or (tx_pop & tx_last), or (tx_pop and burst_cnt==MAX_BURST-1).
  - TX_END lasts 1 cycle with bus_t=1 and wr_n=1, then IDLE, and last_dir is set to TX.
- If usb_txe_n rises while wr_n is low, no pop occurs that cycle; the word stays at the TX buffer head for the next grant.
- rx_afull asserted in the same cycle as a push: that word is still pushed. The RX buffer threshold reserves ≥2 words of margin.
- At no time may bus_t=0 while usb_oe_n=0. Assert this in simulation.
- burst_cnt holds its value in *_END and IDLE until the next grant clears it.

Test Plan:
- RX only, usb_rxf_n low for 20 words. Expected: IDLE→RX_OE→RX_RD; 20 rx_push pulses; usb_rd_n low 20 cycles; burst_cnt=20; RX_END; bus_t stays 1 throughout.
- TX only, 21 words with tx_last on word 21, usb_txe_n=0. Expected: TX_TURN with bus_t=0 one cycle before usb_wr_n falls; 21 tx_pop; exit after tx_last; bus_t=1 in TX_END.
- Both pending continuously, MAX_BURST=8. Expected: grants alternate RX,TX,RX,TX; each burst exactly 8 words; one IDLE cycle between bursts.
- RX with MAX_BURST=16 and 40 words available. Expected: bursts of 16,16,8, each preceded by RX_OE; 40 pushes total with no duplicate or dropped word (data ramp 1..40 checked).
- rx_afull rises after word 5 of an RX burst. Expected: word 5 pushed, exit next cycle, no RX re-grant until rx_afull=0; a pending TX is served meanwhile.
- usb_rstn pulsed low mid-TX_WR. Expected: wr_n=1 and bus_t=1 immediately (asynchronous); tx_pop=0; after release the FSM is in IDLE and serves RX first on a tie.
